// File: rtl/top_memory_access_if.sv
// Data-memory bus between the memory stage (master) and the memory/fabric (slave).
// req/we/addr/be/wdata are held by the master until ack; rdata is valid in the ack cycle.
interface top_memory_access_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/top_memory_access.sv
// Memory stage: load/store over a req/ack bus with lane steering, extension,
// misalign detection and an ack timeout, feeding the *_mw writeback latch.
module top_memory_access #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned OPLEN         = 16,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned MEM_LOAD_BIT  = 0,
    parameter int unsigned MEM_STORE_BIT = 1,
    parameter int unsigned FUNCT3_BIT_L  = 2,
    parameter int unsigned FUNCT3_BIT_M  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 phase_memory,
    input  logic [OPLEN-1:0]     decoded_op_em,
    input  logic [XLEN-1:0]      rs2data_em,
    input  logic                 jump_state_em,
    input  logic [4:0]           rdsel_em,
    input  logic [XLEN-1:0]      next_pc_em,
    input  logic [XLEN-1:0]      alu_out_em,
    top_memory_access_if.master  dmem,
    output logic [OPLEN-1:0]     decoded_op_mw,
    output logic [4:0]           rdsel_mw,
    output logic [XLEN-1:0]      next_pc_mw,
    output logic                 jump_state_mw,
    output logic [XLEN-1:0]      alu_out_mw,
    output logic [XLEN-1:0]      load_data_mw,
    output logic [1:0]           mem_err_mw,
    output logic                 stall_memory
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);
    localparam logic [1:0] ErrOk   = 2'b00;
    localparam logic [1:0] ErrMis  = 2'b01;
    localparam logic [1:0] ErrTo   = 2'b10;

    state_e          r_state;
    state_e          w_state_nxt;

    logic            r_req;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic            r_is_load;
    logic [7:0]      r_cnt;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_memop;
    logic [2:0]      w_f3;
    logic [1:0]      w_off;
    logic            w_misal;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_ext;

    logic            w_stall;
    logic            w_latch;
    logic            w_issue;
    logic            w_done;
    logic [1:0]      w_err;
    logic [XLEN-1:0] w_load;

    assign w_is_load  = decoded_op_em[MEM_LOAD_BIT];
    assign w_is_store = decoded_op_em[MEM_STORE_BIT];
    assign w_memop    = w_is_load | w_is_store;
    assign w_f3       = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];
    assign w_off      = alu_out_em[1:0];

    assign w_misal = ((w_f3[1:0] == 2'b01) && w_off[0]) ||
                     ((w_f3[1:0] == 2'b10) && (w_off != 2'b00));

    // Store lane steering; loads always fetch the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2data_em;
        if (w_is_store) begin
            unique case (w_f3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {(XLEN/8){rs2data_em[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {w_off[1], 1'b0};
                    w_wdata = {(XLEN/16){rs2data_em[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = rs2data_em;
                end
            endcase
        end
    end

    // Extraction uses the offset/width captured at issue, not the live inputs.
    assign w_lane = dmem.rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = dmem.rdata;
        unique case (r_f3)
            3'b000:  w_ext = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
            3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_lane[7:0]};
            3'b001:  w_ext = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            default: w_ext = dmem.rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_latch     = 1'b0;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        w_err       = ErrOk;
        w_load      = '0;
        unique case (r_state)
            StIdle: begin
                if (phase_memory) begin
                    if (!w_memop) begin
                        w_latch = 1'b1;
                    end else if (w_misal) begin
                        w_latch = 1'b1;
                        w_err   = ErrMis;
                    end else begin
                        w_stall     = 1'b1;
                        w_issue     = 1'b1;
                        w_state_nxt = StReq;
                    end
                end
            end
            StReq: begin
                // An ack in the final allowed cycle wins over the timeout.
                if (dmem.ack) begin
                    w_latch     = 1'b1;
                    w_done      = 1'b1;
                    w_load      = r_is_load ? w_ext : '0;
                    w_state_nxt = StIdle;
                end else if (r_cnt == LastCnt) begin
                    w_latch     = 1'b1;
                    w_done      = 1'b1;
                    w_err       = ErrTo;
                    w_state_nxt = StIdle;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= 4'b0000;
            r_wdata   <= '0;
            r_f3      <= 3'b000;
            r_off     <= 2'b00;
            r_is_load <= 1'b0;
            r_cnt     <= 8'd0;
        end else begin
            if (w_issue) begin
                r_req     <= 1'b1;
                r_we      <= w_is_store;
                r_addr    <= {alu_out_em[XLEN-1:2], 2'b00};
                r_be      <= w_be;
                r_wdata   <= w_wdata;
                r_f3      <= w_f3;
                r_off     <= w_off;
                r_is_load <= w_is_load & ~w_is_store;
                r_cnt     <= 8'd0;
            end else if (w_done) begin
                r_req <= 1'b0;
            end else if (r_state == StReq) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decoded_op_mw <= '0;
            rdsel_mw      <= 5'd0;
            next_pc_mw    <= '0;
            jump_state_mw <= 1'b0;
            alu_out_mw    <= '0;
            load_data_mw  <= '0;
            mem_err_mw    <= ErrOk;
        end else if (w_latch) begin
            decoded_op_mw <= decoded_op_em;
            rdsel_mw      <= rdsel_em;
            next_pc_mw    <= next_pc_em;
            jump_state_mw <= jump_state_em;
            alu_out_mw    <= alu_out_em;
            load_data_mw  <= w_load;
            mem_err_mw    <= w_err;
        end
    end

    assign dmem.req     = r_req;
    assign dmem.we      = r_we;
    assign dmem.addr    = r_addr;
    assign dmem.be      = r_be;
    assign dmem.wdata   = r_wdata;
    assign stall_memory = w_stall;

endmodule

// File: tb/tb_top_memory_access.sv
// Self-checking bench for top_memory_access: directed plan cases plus random
// loads/stores against a byte-level reference model.
module tb_top_memory_access;

    localparam int unsigned Tmo = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        phase_memory = 1'b0;
    logic [15:0] decoded_op_em = '0;
    logic [31:0] rs2data_em = '0;
    logic        jump_state_em = 1'b0;
    logic [4:0]  rdsel_em = '0;
    logic [31:0] next_pc_em = '0;
    logic [31:0] alu_out_em = '0;
    logic [15:0] decoded_op_mw;
    logic [4:0]  rdsel_mw;
    logic [31:0] next_pc_mw;
    logic        jump_state_mw;
    logic [31:0] alu_out_mw;
    logic [31:0] load_data_mw;
    logic [1:0]  mem_err_mw;
    logic        stall_memory;

    int checks = 0;
    int failures = 0;

    top_memory_access_if #(.XLEN(32)) bus ();

    top_memory_access #(
        .XLEN(32), .OPLEN(16), .TIMEOUT(Tmo),
        .MEM_LOAD_BIT(0), .MEM_STORE_BIT(1), .FUNCT3_BIT_L(2), .FUNCT3_BIT_M(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .phase_memory  (phase_memory),
        .decoded_op_em (decoded_op_em),
        .rs2data_em    (rs2data_em),
        .jump_state_em (jump_state_em),
        .rdsel_em      (rdsel_em),
        .next_pc_em    (next_pc_em),
        .alu_out_em    (alu_out_em),
        .dmem          (bus),
        .decoded_op_mw (decoded_op_mw),
        .rdsel_mw      (rdsel_mw),
        .next_pc_mw    (next_pc_mw),
        .jump_state_mw (jump_state_mw),
        .alu_out_mw    (alu_out_mw),
        .load_data_mw  (load_data_mw),
        .mem_err_mw    (mem_err_mw),
        .stall_memory  (stall_memory)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one stage transaction; ack_dly = wait cycles before ack (large = never).
    task automatic do_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int ack_dly, input logic [4:0] rd);
        logic [15:0] op;
        logic [31:0] npc, word, v, exp_ld, exp_wd;
        logic [3:0]  exp_be;
        logic [1:0]  exp_err;
        logic        jmp, memop, misal, success, done;
        int          nbytes, off, req_exp, req_cnt, stall_cnt, wait_cnt, cyc;

        op = 16'($urandom);
        op[0] = ld;
        op[1] = st;
        if (ld || st) op[4:2] = f3;
        npc = $urandom;
        jmp = 1'($urandom_range(0, 1));

        // Reference model
        memop   = ld | st;
        nbytes  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off     = int'(addr % 4);
        misal   = memop && ((addr % nbytes) != 0);
        success = (ack_dly < int'(Tmo));
        req_exp = (!memop || misal) ? 0 : (success ? ack_dly + 1 : int'(Tmo));
        exp_err = misal ? 2'd1 : ((memop && !success) ? 2'd2 : 2'd0);
        exp_ld  = 32'd0;
        if (ld && !st && !misal && success) begin
            word = rdata >> (8 * off);
            case (f3)
                3'd0: begin v = word & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
                3'd4: v = word & 32'hFF;
                3'd1: begin v = word & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
                3'd5: v = word & 32'hFFFF;
                default: v = rdata;
            endcase
            exp_ld = v;
        end
        exp_be = 4'b1111;
        exp_wd = rs2;
        if (st) begin
            for (int i = 0; i < 4; i++) begin
                exp_be[i] = (i >= off) && (i < off + nbytes);
                exp_wd[8*i +: 8] = rs2[8*(i % nbytes) +: 8];
            end
        end

        @(negedge clk);
        decoded_op_em = op;
        rs2data_em    = rs2;
        jump_state_em = jmp;
        rdsel_em      = rd;
        next_pc_em    = npc;
        alu_out_em    = addr;
        phase_memory  = 1'b1;
        bus.ack       = 1'b0;
        bus.rdata     = rdata;
        req_cnt = 0; stall_cnt = 0; wait_cnt = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 300) begin
            if (cyc > 0) @(negedge clk);
            if (bus.req) begin
                if (req_cnt == 0) begin
                    chk({tag, ".addr"}, bus.addr, addr & 32'hFFFF_FFFC);
                    chk({tag, ".we"}, 32'(bus.we), 32'(st));
                    chk({tag, ".be"}, 32'(bus.be), 32'(exp_be));
                    if (st) chk({tag, ".wdata"}, bus.wdata, exp_wd);
                end
                bus.ack = (wait_cnt == ack_dly);
                wait_cnt++;
                req_cnt++;
            end else begin
                bus.ack = 1'b0;
            end
            #1;
            if (stall_memory) stall_cnt++;
            else done = 1'b1;
            cyc++;
        end
        chk({tag, ".bound"}, 32'(done), 32'd1);

        @(negedge clk);
        phase_memory = 1'b0;
        bus.ack      = 1'b0;
        #1;
        chk({tag, ".req_cycles"}, req_cnt, req_exp);
        chk({tag, ".stall_cycles"}, stall_cnt, req_exp);
        chk({tag, ".req_after"}, 32'(bus.req), 32'd0);
        chk({tag, ".err"}, 32'(mem_err_mw), 32'(exp_err));
        chk({tag, ".load"}, load_data_mw, exp_ld);
        chk({tag, ".alu_mw"}, alu_out_mw, addr);
        chk({tag, ".rd_mw"}, 32'(rdsel_mw), 32'(rd));
        chk({tag, ".pc_mw"}, next_pc_mw, npc);
        chk({tag, ".jmp_mw"}, 32'(jump_state_mw), 32'(jmp));
        chk({tag, ".op_mw"}, 32'(decoded_op_mw), 32'(op));

        // Idle with phase low: latch must hold.
        alu_out_em = ~addr;
        @(negedge clk);
        #1;
        chk({tag, ".hold"}, alu_out_mw, addr);
        chk({tag, ".idle_stall"}, 32'(stall_memory), 32'd0);
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] f3;
        logic       ld, st;
        int         kind, dly;
        ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

        bus.ack   = 1'b0;
        bus.rdata = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.req", 32'(bus.req), 32'd0);
        chk("rst.we", 32'(bus.we), 32'd0);
        chk("rst.addr", bus.addr, 32'd0);
        chk("rst.be", 32'(bus.be), 32'd0);
        chk("rst.wdata", bus.wdata, 32'd0);
        chk("rst.alu_mw", alu_out_mw, 32'd0);
        chk("rst.load_mw", load_data_mw, 32'd0);
        chk("rst.err_mw", 32'(mem_err_mw), 32'd0);
        chk("rst.op_mw", 32'(decoded_op_mw), 32'd0);
        chk("rst.stall", 32'(stall_memory), 32'd0);
        rst = 1'b0;

        do_op("nonmem", 1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 32'd0, 0, 5'd5);
        do_op("lb",     1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 5'd7);
        do_op("sh",     1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'hABCD_1234, 32'd0, 3, 5'd0);
        do_op("lw_mis", 1'b1, 1'b0, 3'd2, 32'h0000_0301, 32'd0, 32'hDEAD_BEEF, 0, 5'd9);
        do_op("lhu_to", 1'b1, 1'b0, 3'd5, 32'h0000_0400, 32'd0, 32'h1234_5678, 1000, 5'd3);
        do_op("ack_last", 1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'd0, 32'hCAFE_F00D, 3, 5'd4);

        // Reset in the middle of a pending access.
        @(negedge clk);
        decoded_op_em = 16'h0009;
        alu_out_em    = 32'h0000_0600;
        phase_memory  = 1'b1;
        bus.ack       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid.req_before", 32'(bus.req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid.req", 32'(bus.req), 32'd0);
        chk("rstmid.alu_mw", alu_out_mw, 32'd0);
        chk("rstmid.rd_mw", 32'(rdsel_mw), 32'd0);
        chk("rstmid.err_mw", 32'(mem_err_mw), 32'd0);
        chk("rstmid.op_mw", 32'(decoded_op_mw), 32'd0);
        phase_memory = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_op("lbu_after", 1'b1, 1'b0, 3'd4, 32'h0000_0000, 32'd0, 32'h0000_00FF, 0, 5'd1);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            ld = (kind == 1);
            st = (kind == 2);
            if (ld) f3 = ld_f3[$urandom_range(0, 4)];
            else if (st) f3 = 3'($urandom_range(0, 2));
            else f3 = 3'($urandom);
            dly = $urandom_range(0, 5);
            if (dly == 5) dly = 1000;
            do_op($sformatf("rnd%0d", n), ld, st, f3, $urandom, $urandom, $urandom, dly,
                  5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/top_memory_access.md
Name: top_memory_access

Overview:
- Memory stage, directly downstream of the execute stage; consumes the `*_em` latch outputs.
- Performs load/store on the data-memory bus with a req/ack handshake, byte-lane steering, sign/zero extension, misalign detection and an ack timeout.
- Latches results into the `*_mw` register for writeback.
- Drives `stall_memory` to the state machine while a bus access is pending.

Parameters:
- XLEN, 32, datapath width (from core_general.vh).
- OPLEN, core_general.vh value, decoded-opcode width.
- TIMEOUT, 255, REQ cycles without ack before abort (1..255).

Ports:
- clk  in  1  global clock
- rst  in  1  asynchronous, active-high reset
- phase_memory  in  1  memory phase; held high by state machine while stall_memory=1
- decoded_op_em  in  OPLEN  decoded opcode; uses MEM_LOAD_BIT, MEM_STORE_BIT, FUNCT3_BIT_M:FUNCT3_BIT_L
- rs2data_em  in  XLEN  store data
- jump_state_em  in  1  jump flag, passed through
- rdsel_em  in  5  destination register, passed through
- next_pc_em  in  XLEN  passed through
- alu_out_em  in  XLEN  effective address / ALU result
- dmem_req  out  1  bus request (registered)
- dmem_we  out  1  1=write (registered)
- dmem_addr  out  XLEN  {addr[XLEN-1:2],2'b00} (registered)
- dmem_be  out  4  byte enables (registered)
- dmem_wdata  out  XLEN  lane-steered store data (registered)
- dmem_ack  in  1  access complete; rdata valid same cycle
- dmem_rdata  in  XLEN  read word
- decoded_op_mw  out  OPLEN  latched opcode
- rdsel_mw  out  5  latched rd
- next_pc_mw  out  XLEN  latched next PC
- jump_state_mw  out  1  latched jump flag
- alu_out_mw  out  XLEN  latched ALU result
- load_data_mw  out  XLEN  extended load data (0 for non-loads)
- mem_err_mw  out  2  00 ok, 01 misaligned, 10 timeout
- stall_memory  out  1  stall request to state machine

Behaviour:
- Reset: all outputs, latch, FSM and counter 0. State IDLE.
- Reset mid-access: dmem_req drops asynchronously and the transaction is discarded.
- memop = MEM_LOAD_BIT | MEM_STORE_BIT; f3 = funct3 field.
- Misaligned when either holds:
  - f3[1:0]=01 and addr[0]=1
  - f3[1:0]=10 and addr[1:0]≠00
- FSM states: IDLE, REQ.
- IDLE, phase_memory=1:
  - Non-memop: stall_memory=0, `_mw` latch updated at this edge, load_data=0, err=00. One-cycle latency.
  - Memop and misaligned: stall=0, latch updated with err=01, load_data=0, no bus request.
  - Memop and aligned: stall=1; register addr/we/be/wdata; dmem_req=1 from next cycle; counter cleared; go REQ.
- REQ:
  - dmem_req stays 1.
  - dmem_ack=0: stall=1, counter++.
  - dmem_ack=1: stall=0, latch updated at this edge with extracted rdata (loads), err=00; dmem_req=0 next cycle; go IDLE.
  - Counter reaches TIMEOUT with no ack: stall=0, latch err=10, load_data=0, dmem_req=0 next cycle, go IDLE.
  - Ack in the timeout cycle counts as success.
  - Minimum memop latency: 2 cycles with ack in the first REQ cycle.
- Store steering:
  - SB: wdata={4{rs2[7:0]}}, be=0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=0011<<{addr[1],1'b0}.
  - SW: wdata=rs2, be=1111.
- Loads: be=1111, we=0. Lane=rdata>>(8*addr[1:0]).
  - LB sign-extends bit7; LBU zero-extends.
  - LH sign-extends bit15; LHU zero-extends.
  - LW uses the full word.
- phase_memory=0 in IDLE: latch holds, stall=0.
- Pass-through fields are captured from the `*_em` inputs at the latch edge. Upstream holds them stable while stalled.

Test Plan:
- Non-memop (alu_out_em=0x1234, rdsel_em=5), phase_memory one cycle → next cycle alu_out_mw=0x1234, rdsel_mw=5, stall_memory never 1, dmem_req never 1.
- LB, addr 0x103, rdata=0x80FF_0000, ack on first REQ cycle → dmem_addr=0x100, be=1111; load_data_mw=0xFFFF_FF80; stall high exactly 1 cycle.
- SH, addr 0x202, rs2=0xABCD_1234, ack after 3 wait cycles → dmem_we=1, be=1100, wdata=0x1234_1234; stall high 4 cycles; err=00.
- LW, addr 0x301 → no dmem_req; mem_err_mw=01, load_data_mw=0, stall 0.
- LHU, addr 0x400, ack never asserted, TIMEOUT=4 → dmem_req high 4 cycles then 0; mem_err_mw=10; stall deasserts in the 4th REQ cycle.
- rst asserted during REQ → dmem_req=0 and latch 0 immediately; a following LBU (addr 0x0, rdata=0xFF) returns 0x0000_00FF.
